// File: rtl/jtframe_tile_pkg.sv
// Shared tile geometry, map-entry layout and pixel nibble selection for the tile fetcher.
package jtframe_tile_pkg;

    localparam int TILE_W   = 8;
    localparam int ROW_BITS = 3;

    localparam int ATTR_CW   = 10;
    localparam int ATTR_PALW = 4;

    // Map RAM word layout, MSB first: {hflip, pal, code}
    typedef struct packed {
        logic                 hflip;
        logic [ATTR_PALW-1:0] pal;
        logic [ATTR_CW-1:0]   code;
    } tile_attr_t;

    // Nibble 0 is the leftmost pixel; hflip mirrors the column (7 - idx)
    function automatic logic [3:0] nibble_sel(input logic [31:0]         row,
                                              input logic [ROW_BITS-1:0] idx,
                                              input logic                hflip);
        logic [ROW_BITS-1:0] n;
        n = hflip ? ~idx : idx;
        return row[{n, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/jtframe_tilefetch_cache.sv
// Two-entry tile column store: current and prefetched column, with hit compare,
// promotion of the prefetched entry and the pixel nibble mux.
module jtframe_tilefetch_cache
    import jtframe_tile_pkg::*;
#(
    parameter int HW   = 8,
    parameter int PALW = 4
)(
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   inval,
    input  logic [HW-ROW_BITS-1:0] tag,
    input  logic [ROW_BITS-1:0]    idx,
    input  logic                   wr,
    input  logic                   wr_nxt,
    input  logic [HW-ROW_BITS-1:0] wr_tag,
    input  logic                   wr_hflip,
    input  logic [PALW-1:0]        wr_pal,
    input  logic [31:0]            wr_row,
    output logic                   hit,
    output logic                   next_ready,
    output logic [PALW+3:0]        pxl
);

    localparam int TW = HW - ROW_BITS;

    logic          cur_v, nxt_v;
    logic [TW-1:0] cur_tag, nxt_tag, tag_inc;
    logic          cur_hflip, nxt_hflip;
    logic [PALW-1:0] cur_pal, nxt_pal;
    logic [31:0]   cur_row, nxt_row;
    logic          hit_cur, hit_nxt;

    assign tag_inc    = tag + 1'b1;
    assign hit_cur    = cur_v && cur_tag == tag;
    assign hit_nxt    = nxt_v && nxt_tag == tag;
    // A pending invalidation means the entries belong to the previous line's scroll
    assign hit        = !inval && (hit_cur || hit_nxt);
    assign next_ready = (nxt_v && nxt_tag == tag_inc) || (cur_v && cur_tag == tag_inc);

    always_comb begin
        pxl = '0;
        if (hit) begin
            if (hit_cur) pxl = {cur_pal, nibble_sel(cur_row, idx, cur_hflip)};
            else         pxl = {nxt_pal, nibble_sel(nxt_row, idx, nxt_hflip)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_v     <= 1'b0;
            cur_tag   <= '0;
            cur_hflip <= 1'b0;
            cur_pal   <= '0;
            cur_row   <= '0;
            nxt_v     <= 1'b0;
            nxt_tag   <= '0;
            nxt_hflip <= 1'b0;
            nxt_pal   <= '0;
            nxt_row   <= '0;
        end else if (inval) begin
            cur_v <= 1'b0;
            nxt_v <= 1'b0;
        end else begin
            if (!hit_cur && hit_nxt) begin
                cur_v     <= 1'b1;
                cur_tag   <= nxt_tag;
                cur_hflip <= nxt_hflip;
                cur_pal   <= nxt_pal;
                cur_row   <= nxt_row;
                nxt_v     <= 1'b0;
            end
            if (wr && wr_nxt) begin
                nxt_v     <= 1'b1;
                nxt_tag   <= wr_tag;
                nxt_hflip <= wr_hflip;
                nxt_pal   <= wr_pal;
                nxt_row   <= wr_row;
            end else if (wr) begin
                cur_v     <= 1'b1;
                cur_tag   <= wr_tag;
                cur_hflip <= wr_hflip;
                cur_pal   <= wr_pal;
                cur_row   <= wr_row;
            end
        end
    end

endmodule

// File: rtl/jtframe_tilefetch.sv
// Per-scanline tile fetch sequencer: map RAM read, then one ROM row per tile column,
// feeding the line buffer through a two-entry column cache with one-tile prefetch.
module jtframe_tilefetch
    import jtframe_tile_pkg::*;
#(
    parameter int HW   = 8,
    parameter int VW   = 8,
    parameter int CW   = 10,
    parameter int PALW = 4,
    parameter int PW   = PALW + 4,
    parameter int MAPW = 10
)(
    input  logic                  rst,
    input  logic                  clk,
    input  logic [HW-1:0]         hscan,
    input  logic [VW-1:0]         vscan,
    input  logic [HW-1:0]         hscr,
    input  logic [VW-1:0]         vscr,
    output logic [MAPW-1:0]       map_addr,
    input  logic [CW+PALW:0]      map_data,
    output logic [CW+2:0]         rom_addr,
    output logic                  rom_cs,
    input  logic                  rom_ok,
    input  logic [31:0]           rom_data,
    output logic [PW-1:0]         pxl_data,
    output logic                  pxl_ok
);

    localparam int TW = HW - ROW_BITS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MAPWAIT = 2'd1;
    localparam logic [1:0] ST_ROMREQ  = 2'd2;

    logic [1:0]          st;
    logic [VW-1:0]       vscan_q, vscr_l, vpos;
    logic [HW-1:0]       hscr_l, hpos;
    logic                vchg;
    logic                hit, next_ready;
    logic                start_miss, start_pre, wr;
    logic [TW-1:0]       fetch_tag, ftag_q;
    logic [ROW_BITS-1:0] row_q;
    logic                pre_q, stale_q, hflip_q;
    logic [PALW-1:0]     pal_q;

    assign vchg = vscan != vscan_q;
    assign hpos = hscan + hscr_l;
    assign vpos = vscan + vscr_l;

    // No new fetch while the scroll is being relatched: hpos/vpos are still stale
    assign start_miss = !vchg && !hit;
    assign start_pre  = !vchg && hit && hpos[ROW_BITS-1] && !next_ready;
    assign fetch_tag  = hpos[HW-1:ROW_BITS] + {{(TW-1){1'b0}}, start_pre};
    assign wr         = st == ST_ROMREQ && rom_ok && !stale_q && !vchg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            vscan_q  <= '0;
            hscr_l   <= '0;
            vscr_l   <= '0;
            map_addr <= '0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
            ftag_q   <= '0;
            row_q    <= '0;
            pre_q    <= 1'b0;
            stale_q  <= 1'b0;
            hflip_q  <= 1'b0;
            pal_q    <= '0;
        end else begin
            vscan_q <= vscan;
            if (vchg) begin
                hscr_l <= hscr;
                vscr_l <= vscr;
            end
            case (st)
                ST_IDLE: if (start_miss || start_pre) begin
                    map_addr <= {vpos[VW-1:ROW_BITS], fetch_tag};
                    ftag_q   <= fetch_tag;
                    row_q    <= vpos[ROW_BITS-1:0];
                    pre_q    <= start_pre;
                    stale_q  <= 1'b0;
                    st       <= ST_MAPWAIT;
                end
                ST_MAPWAIT: begin
                    hflip_q  <= map_data[CW+PALW];
                    pal_q    <= map_data[CW +: PALW];
                    rom_addr <= {map_data[CW-1:0], row_q};
                    rom_cs   <= 1'b1;
                    st       <= ST_ROMREQ;
                end
                ST_ROMREQ: if (rom_ok) begin
                    rom_cs <= 1'b0;
                    st     <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
            // The slot transfer still completes, but its row is dropped
            if (vchg && st != ST_IDLE) stale_q <= 1'b1;
        end
    end

    jtframe_tilefetch_cache #(
        .HW   (HW),
        .PALW (PALW)
    ) u_cache (
        .rst        (rst),
        .clk        (clk),
        .inval      (vchg),
        .tag        (hpos[HW-1:ROW_BITS]),
        .idx        (hpos[ROW_BITS-1:0]),
        .wr         (wr),
        .wr_nxt     (pre_q),
        .wr_tag     (ftag_q),
        .wr_hflip   (hflip_q),
        .wr_pal     (pal_q),
        .wr_row     (rom_data),
        .hit        (hit),
        .next_ready (next_ready),
        .pxl        (pxl_data)
    );

    assign pxl_ok = hit;

endmodule

// File: tb/tb_jtframe_tilefetch.sv
// Directed bench for jtframe_tilefetch: map RAM and ROM slot modelled in the bench.
module tb_jtframe_tilefetch;
    import jtframe_tile_pkg::*;

    logic        rst, clk;
    logic [7:0]  hscan, vscan, hscr, vscr;
    logic [9:0]  map_addr;
    logic [14:0] map_data;
    logic [12:0] rom_addr;
    logic        rom_cs, rom_ok;
    logic [31:0] rom_data;
    logic [7:0]  pxl_data;
    logic        pxl_ok;

    tile_attr_t map_mem [1024];
    assign map_data = map_mem[map_addr];

    int n_checks = 0;
    int n_errors = 0;

    jtframe_tilefetch u_dut (
        .rst      (rst),
        .clk      (clk),
        .hscan    (hscan),
        .vscan    (vscan),
        .hscr     (hscr),
        .vscr     (vscr),
        .map_addr (map_addr),
        .map_data (map_data),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .pxl_data (pxl_data),
        .pxl_ok   (pxl_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ok(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (pxl_ok) break;
        end
        check(tag, 32'(pxl_ok), 32'd1);
    endtask

    task automatic wait_cs(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rom_cs) break;
        end
        check(tag, 32'(rom_cs), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) map_mem[i] = '0;
        rst = 1'b1; hscan = '0; vscan = '0; hscr = '0; vscr = '0;
        rom_ok = 1'b1; rom_data = 32'h7654_3210;
        map_mem[0] = tile_attr_t'{hflip: 1'b0, pal: 4'd3, code: 10'h005};
        repeat (2) @(negedge clk);
        check("rst_map_addr", 32'(map_addr), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_cs",   32'(rom_cs),   32'd0);
        check("rst_pxl_ok",   32'(pxl_ok),   32'd0);
        check("rst_pxl_data", 32'(pxl_data), 32'd0);

        // First tile: miss, map read, ROM read, pixels three cycles after the miss
        rst = 1'b0;
        @(negedge clk);
        check("t1_map_addr", 32'(map_addr), 32'd0);
        check("t1_ok_c1",    32'(pxl_ok),   32'd0);
        @(negedge clk);
        check("t1_rom_cs",   32'(rom_cs),   32'd1);
        check("t1_rom_addr", 32'(rom_addr), 32'h28);
        check("t1_ok_c2",    32'(pxl_ok),   32'd0);
        @(negedge clk);
        check("t1_ok_c3",    32'(pxl_ok),   32'd1);
        for (int i = 0; i < TILE_W; i++) begin
            hscan = 8'(i);
            #1;
            check("t1_pxl", 32'(pxl_data), 32'h30 + 32'(i));
            @(negedge clk);
        end

        // hflip: vscan change forces a refetch
        map_mem[0] = tile_attr_t'{hflip: 1'b1, pal: 4'd3, code: 10'h005};
        vscan = 8'd1; hscan = 8'd0;
        wait_ok("t2_ok", 10);
        for (int i = 0; i < TILE_W; i++) begin
            hscan = 8'(i);
            #1;
            check("t2_pxl", 32'(pxl_data), 32'h37 - 32'(i));
            @(negedge clk);
        end

        // ROM slot held off for 20 cycles
        map_mem[0] = tile_attr_t'{hflip: 1'b0, pal: 4'd3, code: 10'h005};
        rom_ok = 1'b0; vscan = 8'd2; hscan = 8'd0;
        wait_cs("t3_cs_up", 10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_cs_hold",   32'(rom_cs),   32'd1);
            check("t3_addr_hold", 32'(rom_addr), 32'h2A);
            check("t3_ok_low",    32'(pxl_ok),   32'd0);
        end
        rom_ok = 1'b1;
        wait_ok("t3_ok", 5);
        check("t3_pxl", 32'(pxl_data), 32'h30);

        // Full line sweep, one pixel per clock
        for (int k = 0; k < 32; k++) begin
            map_mem[k] = tile_attr_t'{hflip: 1'b0, pal: 4'(k), code: 10'(k)};
        end
        vscan = 8'd3; hscan = 8'd0;
        wait_ok("t4_ok_start", 10);
        for (int h = 0; h < 256; h++) begin
            hscan = 8'(h);
            #1;
            check("t4_ok",  32'(pxl_ok), 32'd1);
            check("t4_pxl", 32'(pxl_data), {24'd0, 4'(h / 8), 4'(h % 8)});
            if (h % 8 == 0) check("t4_map_addr", 32'(map_addr), 32'(h / 8));
            @(negedge clk);
        end

        // Scroll latched at line start
        map_mem[32] = tile_attr_t'{hflip: 1'b0, pal: 4'd9, code: 10'h03A};
        hscr = 8'd4; vscr = 8'd9; vscan = 8'd0; hscan = 8'd0;
        wait_ok("t5_ok", 10);
        check("t5_map_addr", 32'(map_addr), 32'd32);
        check("t5_rom_addr", 32'(rom_addr), {19'd0, 10'h03A, 3'd1});
        check("t5_pxl",      32'(pxl_data), 32'h94);
        repeat (5) @(negedge clk);

        // Line change while the ROM request is outstanding
        rom_ok = 1'b0; hscr = 8'd0; vscr = 8'd0; vscan = 8'd1; hscan = 8'd0;
        map_mem[0] = tile_attr_t'{hflip: 1'b0, pal: 4'd3, code: 10'h005};
        wait_cs("t6_cs_up", 10);
        check("t6_rom_addr0", 32'(rom_addr), 32'h29);
        vscan = 8'd2; vscr = 8'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_cs_hold",   32'(rom_cs),   32'd1);
            check("t6_addr_hold", 32'(rom_addr), 32'h29);
            check("t6_ok_low",    32'(pxl_ok),   32'd0);
        end
        rom_ok = 1'b1;
        @(negedge clk);
        check("t6_discard_ok", 32'(pxl_ok), 32'd0);
        check("t6_cs_drop",    32'(rom_cs), 32'd0);
        wait_ok("t6_ok", 10);
        check("t6_map_addr", 32'(map_addr), 32'd32);
        check("t6_rom_addr", 32'(rom_addr), {19'd0, 10'h03A, 3'd2});
        check("t6_pxl",      32'(pxl_data), 32'h90);

        // Asynchronous reset mid-request
        rom_ok = 1'b0; vscan = 8'd3;
        wait_cs("t7_cs_up", 10);
        #2;
        rst = 1'b1;
        #1;
        check("t7_cs_async", 32'(rom_cs), 32'd0);
        check("t7_ok_async", 32'(pxl_ok), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
